puf_challenge_sequencer: RTL and testbench

//  Upstream driver of the RO-PUF / number-conversion / scan-enable chain.

---
 rtl/puf_pkg.sv | 30 +++
 rtl/puf_lfsr16.sv | 39 +++
 rtl/puf_challenge_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF challenge sequencer: widths, LFSR taps,
// evaluation count and the sequencer state encoding.
package puf_pkg;

    localparam int CHAL_W   = 16;
    localparam int RESP_W   = 16;
    localparam int NUM_EVAL = 5;
    localparam int TIMEOUT  = 1024;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_POLY  = 16'hB400;
    localparam logic [15:0] LFSR_RESET = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

    // One right-shifting Galois step; the dropped LSB selects the taps.
    function automatic logic [15:0] lfsr_next16(
        input logic [15:0] s,
        input logic [15:0] poly
    );
        return {1'b0, s[15:1]} ^ (s[0] ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/puf_lfsr16.sv
// Galois LFSR holding the PUF challenge.
// Ports: clk, rst (async high), load/seed (seed 0 maps to 1), step, state.
module puf_lfsr16
    import puf_pkg::*;
#(
    parameter int          W    = CHAL_W,
    parameter logic [W-1:0] POLY = W'(LFSR_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         step,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] state_q;
    logic [W-1:0] state_step;

    always_comb begin
        state_step = {1'b0, state_q[W-1:1]} ^ (state_q[0] ? POLY : '0);
    end

    // An all-zero state would lock up, so a zero seed is forced to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ONE;
        end else if (load) begin
            state_q <= (seed == '0) ? ONE : seed;
        end else if (step) begin
            state_q <= state_step;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives the RO-PUF with an LFSR challenge, evaluates it NUM_EVAL times
// and produces a per-bit majority-voted response plus a stability mask.
// Ports: clk, rst (async high); start, seed_load, seed, activation_in;
//        puf_challenge, puf_activation_ctrl, puf_generate to the PUF;
//        puf_ready, puf_response from the PUF; busy, voted_response,
//        stable_mask, resp_valid, timeout_err as results.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int               CHAL_W    = puf_pkg::CHAL_W,
    parameter int               RESP_W    = puf_pkg::RESP_W,
    parameter int               NUM_EVAL  = puf_pkg::NUM_EVAL,
    parameter int               TIMEOUT   = puf_pkg::TIMEOUT,
    parameter logic [CHAL_W-1:0] LFSR_POLY = CHAL_W'(puf_pkg::LFSR_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              seed_load,
    input  logic [CHAL_W-1:0] seed,
    input  logic [3:0]        activation_in,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic [3:0]        puf_activation_ctrl,
    output logic              puf_generate,
    input  logic              puf_ready,
    input  logic [RESP_W-1:0] puf_response,
    output logic              busy,
    output logic [RESP_W-1:0] voted_response,
    output logic [RESP_W-1:0] stable_mask,
    output logic              resp_valid,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(NUM_EVAL + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(NUM_EVAL - 1);
    localparam logic [CNT_W-1:0] EVAL_ALL  = CNT_W'(NUM_EVAL);
    localparam logic [CNT_W-1:0] EVAL_HALF = CNT_W'(NUM_EVAL / 2);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

    seq_state_t state_q;
    seq_state_t state_d;

    logic [CNT_W-1:0]  vote_cnt [RESP_W];
    logic [CNT_W-1:0]  eval_cnt_q;
    logic [TMR_W-1:0]  timer_q;
    logic [RESP_W-1:0] sample_q;
    logic [3:0]        act_q;
    logic              ready_q;
    logic              ready_rise;
    logic              tmr_expired;
    logic              lfsr_load;
    logic              lfsr_step;

    // Only a low-to-high transition counts as a new response.
    assign ready_rise  = puf_ready & ~ready_q;
    assign tmr_expired = (timer_q == TMR_LAST);

    puf_lfsr16 #(
        .W    (CHAL_W),
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .state (puf_challenge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Seed is written on the same edge start is taken,
                // so a combined request runs with the new seed.
                lfsr_load = seed_load;
                if (start) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_rise) begin
                    state_d = ST_ACCUM;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (eval_cnt_q == EVAL_LAST) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                lfsr_step = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign puf_generate        = (state_q == ST_ISSUE);
    assign busy                = (state_q != ST_IDLE);
    assign puf_activation_ctrl = act_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q        <= 1'b0;
            eval_cnt_q     <= '0;
            timer_q        <= '0;
            sample_q       <= '0;
            act_q          <= '0;
            voted_response <= '0;
            stable_mask    <= '0;
            resp_valid     <= 1'b0;
            timeout_err    <= 1'b0;
            for (int i = 0; i < RESP_W; i++) begin
                vote_cnt[i] <= '0;
            end
        end else begin
            ready_q     <= puf_ready;
            resp_valid  <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        act_q      <= activation_in;
                        eval_cnt_q <= '0;
                        for (int i = 0; i < RESP_W; i++) begin
                            vote_cnt[i] <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                end
                ST_WAIT: begin
                    if (ready_rise) begin
                        sample_q <= puf_response;
                    end else if (tmr_expired) begin
                        timeout_err <= 1'b1;
                        eval_cnt_q  <= '0;
                        timer_q     <= '0;
                        for (int i = 0; i < RESP_W; i++) begin
                            vote_cnt[i] <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_ACCUM: begin
                    eval_cnt_q <= eval_cnt_q + CNT_W'(1);
                    for (int i = 0; i < RESP_W; i++) begin
                        vote_cnt[i] <= vote_cnt[i] + CNT_W'(sample_q[i]);
                    end
                end
                ST_FINISH: begin
                    resp_valid <= 1'b1;
                    for (int i = 0; i < RESP_W; i++) begin
                        voted_response[i] <= (vote_cnt[i] > EVAL_HALF);
                        stable_mask[i]    <= (vote_cnt[i] == '0)
                                          || (vote_cnt[i] == EVAL_ALL);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized self-checking bench for puf_challenge_sequencer with a
// behavioural PUF responder and a per-cycle output model.
module tb_puf_challenge_sequencer;

    localparam int NE  = 5;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = '0;
    logic [3:0]  activation_in = '0;
    logic        puf_ready = 1'b0;
    logic [15:0] puf_response = '0;
    logic [15:0] puf_challenge;
    logic [3:0]  puf_activation_ctrl;
    logic        puf_generate;
    logic        busy;
    logic [15:0] voted_response;
    logic [15:0] stable_mask;
    logic        resp_valid;
    logic        timeout_err;

    puf_challenge_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .seed_load           (seed_load),
        .seed                (seed),
        .activation_in       (activation_in),
        .puf_challenge       (puf_challenge),
        .puf_activation_ctrl (puf_activation_ctrl),
        .puf_generate        (puf_generate),
        .puf_ready           (puf_ready),
        .puf_response        (puf_response),
        .busy                (busy),
        .voted_response      (voted_response),
        .stable_mask         (stable_mask),
        .resp_valid          (resp_valid),
        .timeout_err         (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference rules, written from the behaviour description.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    logic [15:0] resp [NE];
    logic [15:0] nxt_voted, nxt_stable;
    logic [15:0] exp_chal, exp_voted, exp_stable;
    logic [3:0]  cur_act;
    bit          seed_take_ok = 1'b0;

    task automatic model_vote();
        int ones;
        nxt_voted  = '0;
        nxt_stable = '0;
        for (int b = 0; b < 16; b++) begin
            ones = 0;
            for (int e = 0; e < NE; e++) ones += int'(resp[e][b]);
            nxt_voted[b]  = (ones * 2 > NE);
            nxt_stable[b] = (ones == 0) || (ones == NE);
        end
    endtask

    // Per-cycle compare: challenge, voted result and mask always valid.
    always @(posedge clk) begin
        bit          sl;
        logic [15:0] sd;
        sl = seed_load && seed_take_ok;
        sd = seed;
        #2;
        if (rst) begin
            exp_chal   = 16'h0001;
            exp_voted  = '0;
            exp_stable = '0;
        end else begin
            if (sl) exp_chal = (sd == 16'h0000) ? 16'h0001 : sd;
            if (resp_valid) begin
                exp_chal   = lfsr_next(exp_chal);
                exp_voted  = nxt_voted;
                exp_stable = nxt_stable;
            end
        end
        chk16("mon_challenge", puf_challenge, exp_chal);
        chk16("mon_voted", voted_response, exp_voted);
        chk16("mon_stable", stable_mask, exp_stable);
        chk("mon_excl", int'(resp_valid && timeout_err), 0);
    end

    task automatic seed_only(input logic [15:0] sd);
        seed_load    = 1'b1;
        seed         = sd;
        seed_take_ok = 1'b1;
        @(negedge clk);
        seed_load    = 1'b0;
        seed_take_ok = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] act, input bit ws,
                               input logic [15:0] sd, output int t_s);
        start         = 1'b1;
        activation_in = act;
        seed_load     = ws;
        seed          = sd;
        seed_take_ok  = ws;
        cur_act       = act;
        t_s           = cyc;
        @(negedge clk);
        start         = 1'b0;
        seed_load     = 1'b0;
        seed_take_ok  = 1'b0;
        activation_in = 4'($urandom);
    endtask

    task automatic run_evals(input int k, input bit poke, input bit glitch,
                             input int rst_eval, output bit aborted,
                             output int gens);
        int n;
        gens    = 0;
        aborted = 1'b0;
        for (int e = 0; e < NE; e++) begin
            n = 0;
            while (!puf_generate && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!puf_generate) begin
                chk("gen_seen", 0, 1);
                aborted = 1'b1;
                return;
            end
            gens++;
            chk("busy_run", int'(busy), 1);
            chk("act_ctrl", int'(puf_activation_ctrl), int'(cur_act));
            if (e == rst_eval) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                chk16("rst_chal", puf_challenge, 16'h0001);
                chk16("rst_voted", voted_response, 16'h0000);
                chk16("rst_stable", stable_mask, 16'h0000);
                chk("rst_outs", int'({busy, puf_generate, resp_valid,
                                      timeout_err, puf_activation_ctrl}), 0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (glitch) puf_ready = 1'b1;
            for (int j = 0; j < k; j++) begin
                @(negedge clk);
                if (glitch && j == 0) puf_ready = 1'b0;
                if (poke && e == 1 && j == 0) begin
                    start     = 1'b1;
                    seed_load = 1'b1;
                    seed      = 16'($urandom);
                end else begin
                    start     = 1'b0;
                    seed_load = 1'b0;
                end
            end
            puf_ready    = 1'b1;
            puf_response = resp[e];
            @(negedge clk);
            puf_ready    = 1'b0;
            start        = 1'b0;
            seed_load    = 1'b0;
            puf_response = 16'($urandom);
        end
    endtask

    task automatic wait_result(input int t_s, input int k);
        int n;
        n = 0;
        while (!resp_valid && !timeout_err && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("resp_valid_seen", int'(resp_valid), 1);
        chk("latency", cyc - t_s, 2 + NE * (k + 2));
        chk("busy_done", int'(busy), 0);
        @(negedge clk);
        chk("resp_valid_pulse", int'(resp_valid), 0);
    endtask

    task automatic full_run(input logic [3:0] act, input bit ws,
                            input logic [15:0] sd, input int k,
                            input bit poke, input bit glitch);
        int t_s, gens;
        bit ab;
        model_vote();
        pulse_start(act, ws, sd, t_s);
        run_evals(k, poke, glitch, -1, ab, gens);
        chk("gen_count", gens, NE);
        if (!ab) wait_result(t_s, k);
    endtask

    initial begin
        int   t_s, gens, n, k;
        bit   ab, rv_seen;
        logic [15:0] base, chal_before;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk16("reset_chal", puf_challenge, 16'h0001);
        chk("reset_outs", int'({busy, puf_generate, resp_valid, timeout_err,
                               puf_activation_ctrl}), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: constant response
        seed_only(16'hACE1);
        chk16("t1_seed", puf_challenge, 16'hACE1);
        for (int e = 0; e < NE; e++) resp[e] = 16'h5A5A;
        full_run(4'hA, 1'b0, 16'h0, 2, 1'b0, 1'b0);
        chk16("t1_voted", voted_response, 16'h5A5A);
        chk16("t1_stable", stable_mask, 16'hFFFF);
        chk16("t1_next_chal", puf_challenge, 16'hE270);

        // 2: mixed responses
        resp[0] = 16'h5A5A; resp[1] = 16'h5A5B; resp[2] = 16'h5A5A;
        resp[3] = 16'hFA5A; resp[4] = 16'h5A5B;
        full_run(4'h3, 1'b0, 16'h0, 1, 1'b0, 1'b0);
        chk16("t2_voted", voted_response, 16'h5A5A);
        chk16("t2_stable", stable_mask, 16'h5FFE);

        // 4: zero seed guard, then seed+start together
        seed_only(16'h0000);
        chk16("t4_zero_seed", puf_challenge, 16'h0001);
        for (int e = 0; e < NE; e++) resp[e] = 16'($urandom);
        model_vote();
        pulse_start(4'h5, 1'b1, 16'h1234, t_s);
        chk16("t4_seed_start", puf_challenge, 16'h1234);
        run_evals(3, 1'b1, 1'b0, -1, ab, gens);
        chk("t4_gens", gens, NE);
        if (!ab) wait_result(t_s, 3);

        // 3: PUF never answers
        chal_before = puf_challenge;
        pulse_start(4'h9, 1'b0, 16'h0, t_s);
        n = 0;
        rv_seen = 1'b0;
        gens = 0;
        while (!timeout_err && n < TMO + 20) begin
            if (resp_valid) rv_seen = 1'b1;
            if (puf_generate) gens++;
            @(negedge clk);
            n++;
        end
        chk("t3_tmo_seen", int'(timeout_err), 1);
        chk("t3_tmo_time", cyc - t_s, TMO + 2);
        chk("t3_no_resp", int'(rv_seen), 0);
        chk("t3_one_gen", gens, 1);
        chk("t3_busy", int'(busy), 0);
        chk16("t3_chal", puf_challenge, chal_before);
        @(negedge clk);
        chk("t3_tmo_pulse", int'(timeout_err), 0);

        // 6: reset during WAIT of third evaluation
        for (int e = 0; e < NE; e++) resp[e] = 16'($urandom);
        pulse_start(4'hC, 1'b0, 16'h0, t_s);
        run_evals(2, 1'b0, 1'b0, 2, ab, gens);
        chk("t6_aborted", int'(ab), 1);
        @(negedge clk);
        for (int e = 0; e < NE; e++) resp[e] = 16'hC3C3 ^ 16'(e == 2);
        full_run(4'h6, 1'b0, 16'h0, 2, 1'b0, 1'b0);
        chk16("t6_voted", voted_response, 16'hC3C3);
        chk16("t6_stable", stable_mask, 16'hFFFE);

        // 5: pokes while busy and ready edge during ISSUE
        for (int e = 0; e < NE; e++) resp[e] = 16'h0F0F;
        full_run(4'h1, 1'b0, 16'h0, 3, 1'b1, 1'b1);
        chk16("t5_voted", voted_response, 16'h0F0F);

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            base = 16'($urandom);
            for (int e = 0; e < NE; e++)
                resp[e] = base ^ 16'($urandom & $urandom & $urandom);
            k = $urandom_range(1, 4);
            full_run(4'($urandom), 1'($urandom), 16'($urandom), k,
                     1'($urandom), (k >= 2) && 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
